// File: rtl/page_alloc_ctrl_if.sv
// Bundle of requester-side and bitmap-side signals for page_alloc_ctrl.
// The controller uses the slave modport; requesters and the bitmap use master.
interface page_alloc_ctrl_if #(
   parameter int NUM_PORT = 4,
   parameter int ADDR_W   = 10
);
   logic [NUM_PORT-1:0]        alloc_req;
   logic [NUM_PORT-1:0]        alloc_gnt;
   logic [ADDR_W-1:0]          alloc_addr;
   logic [NUM_PORT-1:0]        free_req;
   logic [NUM_PORT*ADDR_W-1:0] free_addr;
   logic [NUM_PORT-1:0]        free_ack;
   logic [ADDR_W-1:0]          bm_ready_addr;
   logic                       bm_ready_vld;
   logic                       bm_full;
   logic                       bm_wr_en_1;
   logic [ADDR_W-1:0]          bm_wr_addr_1;
   logic                       bm_wr_val_1;
   logic                       bm_wr_en_2;
   logic [ADDR_W-1:0]          bm_wr_addr_2;
   logic                       bm_wr_val_2;
   logic [ADDR_W:0]            used_cnt;
   logic                       alloc_full;
   logic                       almost_full;
   logic                       err_underflow;

   modport slave (
      input  alloc_req, free_req, free_addr, bm_ready_addr, bm_ready_vld, bm_full,
      output alloc_gnt, alloc_addr, free_ack, bm_wr_en_1, bm_wr_addr_1, bm_wr_val_1,
             bm_wr_en_2, bm_wr_addr_2, bm_wr_val_2, used_cnt, alloc_full, almost_full,
             err_underflow
   );

   modport master (
      output alloc_req, free_req, free_addr, bm_ready_addr, bm_ready_vld, bm_full,
      input  alloc_gnt, alloc_addr, free_ack, bm_wr_en_1, bm_wr_addr_1, bm_wr_val_1,
             bm_wr_en_2, bm_wr_addr_2, bm_wr_val_2, used_cnt, alloc_full, almost_full,
             err_underflow
   );
endinterface

// File: rtl/page_alloc_ctrl.sv
// Free-page bitmap allocation/release controller.
// Round-robin arbitration for allocate and release requesters; a settle FSM
// hides the bitmap search latency after every allocation, and an occupancy
// counter is kept here because the bitmap's own count loses one of two
// same-cycle writes.
module page_alloc_ctrl #(
   parameter int NUM_PORT    = 4,
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 128,
   parameter int SETTLE      = 4,
   parameter int AMFULL_DIFF = 4
) (
   input logic              clk,
   input logic              rst,
   page_alloc_ctrl_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH) + $clog2(WIDTH);
   localparam int VOLUME = DEPTH * WIDTH;
   localparam int PTR_W  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
   localparam int CNT_W  = $clog2(SETTLE);
   localparam int UCNT_W = ADDR_W + 1;
   localparam logic [UCNT_W-1:0] VOL_C     = UCNT_W'(VOLUME);
   localparam logic [UCNT_W-1:0] AMF_C     = UCNT_W'(VOLUME - AMFULL_DIFF);
   localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   aptr_q, aptr_d;
   logic [PTR_W-1:0]   fptr_q, fptr_d;
   logic               wr_en_1_q, wr_en_1_d;
   logic [ADDR_W-1:0]  wr_addr_1_q, wr_addr_1_d;
   logic               wr_en_2_q, wr_en_2_d;
   logic [ADDR_W-1:0]  wr_addr_2_q, wr_addr_2_d;
   logic [UCNT_W-1:0]  used_q, used_d;
   logic               err_q, err_d;

   logic [PTR_W-1:0]   a_win, f_win;
   logic               grant, ack, full;
   logic [ADDR_W-1:0]  f_sel_addr;

   // First requester at or after ptr, wrapping around.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                                input logic [PTR_W-1:0]    ptr);
      logic [PTR_W-1:0] win;
      logic [PTR_W-1:0] idx;
      logic             found;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_PORT; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_PORT);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == NUM_PORT - 1) ? '0 : p + 1'b1;
   endfunction

   assign full       = bus.bm_full | (used_q == VOL_C);
   assign a_win      = rr_pick(bus.alloc_req, aptr_q);
   assign f_win      = rr_pick(bus.free_req, fptr_q);
   assign grant      = (state_q == S_IDLE) & (|bus.alloc_req) & bus.bm_ready_vld & ~full;
   assign ack        = |bus.free_req;
   assign f_sel_addr = bus.free_addr[int'(f_win)*ADDR_W +: ADDR_W];

   assign bus.alloc_gnt     = grant ? (NUM_PORT'(1) << a_win) : '0;
   assign bus.alloc_addr    = grant ? bus.bm_ready_addr : '0;
   assign bus.free_ack      = ack ? (NUM_PORT'(1) << f_win) : '0;
   assign bus.bm_wr_en_1    = wr_en_1_q;
   assign bus.bm_wr_addr_1  = wr_addr_1_q;
   assign bus.bm_wr_val_1   = 1'b1;
   assign bus.bm_wr_en_2    = wr_en_2_q;
   assign bus.bm_wr_addr_2  = wr_addr_2_q;
   assign bus.bm_wr_val_2   = 1'b0;
   assign bus.used_cnt      = used_q;
   assign bus.alloc_full    = full;
   assign bus.almost_full   = (used_q >= AMF_C);
   assign bus.err_underflow = err_q;

   // Alloc FSM: grant in IDLE, then hold off SETTLE-1 cycles so the bitmap's
   // ready address reflects the page just written before it is sampled again.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      aptr_d      = aptr_q;
      wr_en_1_d   = 1'b0;
      wr_addr_1_d = wr_addr_1_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d     = S_WAIT;
               cnt_d       = SETTLE_LD;
               aptr_d      = ptr_inc(a_win);
               wr_en_1_d   = 1'b1;
               wr_addr_1_d = bus.bm_ready_addr;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Release path and occupancy count; releases never need the settle wait
   // because they only add free pages.
   always_comb begin
      fptr_d      = fptr_q;
      wr_en_2_d   = 1'b0;
      wr_addr_2_d = wr_addr_2_q;
      used_d      = used_q;
      err_d       = err_q;
      if (ack) begin
         fptr_d      = ptr_inc(f_win);
         wr_en_2_d   = 1'b1;
         wr_addr_2_d = f_sel_addr;
      end
      case ({grant, ack})
         2'b10:   used_d = used_q + 1'b1;
         2'b01: begin
            if (used_q == '0) err_d  = 1'b1;
            else              used_d = used_q - 1'b1;
         end
         default: used_d = used_q;
      endcase
   end

   // State, pointers, write ports and counters; reset drops any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         aptr_q      <= '0;
         fptr_q      <= '0;
         wr_en_1_q   <= 1'b0;
         wr_addr_1_q <= '0;
         wr_en_2_q   <= 1'b0;
         wr_addr_2_q <= '0;
         used_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         aptr_q      <= aptr_d;
         fptr_q      <= fptr_d;
         wr_en_1_q   <= wr_en_1_d;
         wr_addr_1_q <= wr_addr_1_d;
         wr_en_2_q   <= wr_en_2_d;
         wr_addr_2_q <= wr_addr_2_d;
         used_q      <= used_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_page_alloc_ctrl.sv
// Bench for page_alloc_ctrl: a simple free-page bitmap with a two-stage
// search pipeline feeds the controller, and a cycle model built from the
// allocation rules (settle spacing, round robin, occupancy) predicts outputs.
module tb_page_alloc_ctrl;
   localparam int NUM_PORT    = 4;
   localparam int WIDTH       = 8;
   localparam int DEPTH       = 128;
   localparam int SETTLE      = 4;
   localparam int AMFULL_DIFF = 4;
   localparam int ADDR_W      = 10;
   localparam int VOLUME      = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   page_alloc_ctrl_if #(.NUM_PORT(NUM_PORT), .ADDR_W(ADDR_W)) bus ();

   page_alloc_ctrl #(
      .NUM_PORT(NUM_PORT), .WIDTH(WIDTH), .DEPTH(DEPTH),
      .SETTLE(SETTLE), .AMFULL_DIFF(AMFULL_DIFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Stimulus
   logic [NUM_PORT-1:0]             a_req;
   logic [NUM_PORT-1:0]             f_req;
   logic [NUM_PORT-1:0][ADDR_W-1:0] f_addr;
   logic                            kill;

   // Bitmap model: one bit per page, search result delayed two cycles
   bit                bmap [VOLUME];
   logic [ADDR_W:0]   s1 = {1'b1, {ADDR_W{1'b0}}};
   logic [ADDR_W:0]   s2 = {1'b1, {ADDR_W{1'b0}}};

   function automatic logic [ADDR_W:0] scan();
      logic [ADDR_W:0] r;
      r = '0;
      for (int i = VOLUME - 1; i >= 0; i--)
         if (!bmap[i]) r = {1'b1, ADDR_W'(i)};
      return r;
   endfunction

   always @(posedge clk) begin
      s1 <= scan();
      s2 <= s1;
      if (bus.bm_wr_en_1 === 1'b1) bmap[bus.bm_wr_addr_1] <= 1'b1;
      if (bus.bm_wr_en_2 === 1'b1) bmap[bus.bm_wr_addr_2] <= 1'b0;
   end

   assign bus.alloc_req     = a_req;
   assign bus.free_req      = f_req;
   assign bus.free_addr     = f_addr;
   assign bus.bm_ready_addr = s2[ADDR_W-1:0];
   assign bus.bm_ready_vld  = s2[ADDR_W] & ~kill;
   assign bus.bm_full       = ~s2[ADDR_W];

   // Reference model state
   int  used_m, aptr_m, fptr_m, since_m;
   bit  err_m;
   bit  ref_alloc [VOLUME];
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  last_gnt, last_ack;
   int  last_port, last_addr, last_ack_port;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NUM_PORT-1:0] r, input int p);
      for (int k = 0; k < NUM_PORT; k++)
         if (r[(p + k) % NUM_PORT]) return (p + k) % NUM_PORT;
      return 0;
   endfunction

   function automatic bit pending(input int page);
      for (int p = 0; p < NUM_PORT; p++)
         if (f_req[p] && int'(f_addr[p]) == page) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: check combinational outputs mid-cycle against the model,
   // advance the model, then check the registered write ports after the edge.
   task automatic step();
      bit                  can, ack, full;
      int                  w, fw;
      logic [NUM_PORT-1:0] eg, ea;
      logic [ADDR_W-1:0]   eaddr, faddr;
      bit                  e_wr1, e_wr2;
      logic [ADDR_W-1:0]   e_a1, e_a2;
      e_wr1 = 0; e_wr2 = 0; e_a1 = '0; e_a2 = '0;
      @(negedge clk);
      last_gnt = 0;
      last_ack = 0;
      if (rst) begin
         used_m = 0; err_m = 0; aptr_m = 0; fptr_m = 0; since_m = SETTLE;
         for (int i = 0; i < VOLUME; i++) ref_alloc[i] = 0;
      end else begin
         w     = pick(a_req, aptr_m);
         fw    = pick(f_req, fptr_m);
         full  = (bus.bm_full === 1'b1) || (used_m == VOLUME);
         can   = (since_m >= SETTLE) && (a_req != 0) && (bus.bm_ready_vld === 1'b1) && !full;
         ack   = (f_req != 0);
         eg    = can ? NUM_PORT'(1) << w : '0;
         eaddr = can ? bus.bm_ready_addr : '0;
         ea    = ack ? NUM_PORT'(1) << fw : '0;
         faddr = f_addr[fw];
         chk("alloc_gnt",     64'(bus.alloc_gnt),     64'(eg));
         chk("alloc_addr",    64'(bus.alloc_addr),    64'(eaddr));
         chk("free_ack",      64'(bus.free_ack),      64'(ea));
         chk("used_cnt",      64'(bus.used_cnt),      64'(used_m));
         chk("alloc_full",    64'(bus.alloc_full),    64'(full));
         chk("almost_full",   64'(bus.almost_full),   64'(used_m >= VOLUME - AMFULL_DIFF));
         chk("err_underflow", 64'(bus.err_underflow), 64'(err_m));
         if (can) begin
            chk("fresh_page", 64'(ref_alloc[eaddr]), 64'(0));
            ref_alloc[eaddr] = 1;
            last_gnt  = 1;
            last_port = w;
            last_addr = int'(eaddr);
            aptr_m    = (w + 1) % NUM_PORT;
            since_m   = 0;
         end
         if (ack) begin
            ref_alloc[faddr] = 0;
            last_ack      = 1;
            last_ack_port = fw;
            fptr_m        = (fw + 1) % NUM_PORT;
         end
         if (can && !ack) used_m++;
         else if (ack && !can) begin
            if (used_m == 0) err_m = 1;
            else used_m--;
         end
         if (since_m < 1000) since_m++;
         e_wr1 = can; e_a1 = eaddr;
         e_wr2 = ack; e_a2 = faddr;
      end
      @(posedge clk);
      #1;
      chk("bm_wr_en_1", 64'(bus.bm_wr_en_1), 64'(e_wr1));
      if (e_wr1) chk("bm_wr_addr_1", 64'(bus.bm_wr_addr_1), 64'(e_a1));
      chk("bm_wr_en_2", 64'(bus.bm_wr_en_2), 64'(e_wr2));
      if (e_wr2) chk("bm_wr_addr_2", 64'(bus.bm_wr_addr_2), 64'(e_a2));
      if (last_ack) f_req[last_ack_port] = 1'b0;
   endtask

   task automatic run_grants(input int n, input int budget, input string tag);
      int got, cyc;
      got = 0;
      cyc = 0;
      while (got < n && cyc < budget) begin
         step();
         cyc++;
         if (last_gnt) got++;
      end
      chk(tag, 64'(got), 64'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, ngnt, cand;
      rst = 1'b1; a_req = '0; f_req = '0; f_addr = '0; kill = 1'b0;
      used_m = 0; err_m = 0; aptr_m = 0; fptr_m = 0; since_m = SETTLE;
      last_gnt = 0; last_ack = 0; last_port = 0; last_addr = 0; last_ack_port = 0;
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      chk("rst_alloc_gnt",  64'(bus.alloc_gnt),     64'(0));
      chk("rst_free_ack",   64'(bus.free_ack),      64'(0));
      chk("rst_wr_en_1",    64'(bus.bm_wr_en_1),    64'(0));
      chk("rst_wr_en_2",    64'(bus.bm_wr_en_2),    64'(0));
      chk("rst_used_cnt",   64'(bus.used_cnt),      64'(0));
      chk("rst_err",        64'(bus.err_underflow), 64'(0));
      chk("wr_val_1",       64'(bus.bm_wr_val_1),   64'(1));
      chk("wr_val_2",       64'(bus.bm_wr_val_2),   64'(0));

      // Release while empty: sticky underflow, count stays 0
      f_addr[0] = 10'd3; f_req = 4'b0001;
      step();
      chk("underflow_err",  64'(bus.err_underflow), 64'(1));
      chk("underflow_used", 64'(bus.used_cnt),      64'(0));

      // Single requester: pages 0..4 granted every SETTLE cycles
      a_req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         run_grants(1, 2 * SETTLE + 4, "p1_grant");
         chk("p1_addr", 64'(last_addr), 64'(i));
      end

      // All requesters: rotation continues from port 1
      a_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         run_grants(1, 2 * SETTLE + 4, "p4_grant");
         chk("p4_port", 64'(last_port), 64'((1 + k) % NUM_PORT));
         chk("p4_addr", 64'(last_addr), 64'(5 + k));
      end
      chk("used_10", 64'(bus.used_cnt), 64'(10));

      // Two releases: port 1 then port 2 on consecutive cycles
      a_req = '0;
      repeat (2) step();
      f_addr[1] = 10'd5; f_addr[2] = 10'd9; f_req = 4'b0110;
      step();
      chk("rel_port_a", 64'(last_ack_port),    64'(1));
      chk("rel_addr_a", 64'(bus.bm_wr_addr_2), 64'(5));
      step();
      chk("rel_port_b", 64'(last_ack_port),    64'(2));
      chk("rel_addr_b", 64'(bus.bm_wr_addr_2), 64'(9));
      step();
      chk("used_8", 64'(bus.used_cnt), 64'(8));

      // Grant and release in the same cycle
      repeat (3) step();
      a_req = 4'b0001; f_addr[0] = 10'd0; f_req = 4'b0001;
      step();
      chk("same_gnt_ack",  64'({last_gnt, last_ack}),              64'(2'b11));
      chk("same_both_wr",  64'({bus.bm_wr_en_1, bus.bm_wr_en_2}),  64'(2'b11));
      chk("same_used",     64'(bus.used_cnt),                      64'(8));
      a_req = '0;

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         a_req = NUM_PORT'($urandom_range(0, 15));
         kill  = ($urandom_range(0, 9) == 0);
         for (int p = 0; p < NUM_PORT; p++) begin
            if (!f_req[p] && $urandom_range(0, 3) == 0) begin
               cand = $urandom_range(0, 63);
               if (ref_alloc[cand] && !pending(cand)) begin
                  f_addr[p] = ADDR_W'(cand);
                  f_req[p]  = 1'b1;
               end
            end
         end
         step();
      end
      kill = 1'b0; a_req = '0;
      cyc = 0;
      while (f_req != 0 && cyc < 10) begin step(); cyc++; end
      chk("rand_drain", 64'(f_req), 64'(0));

      // Fill to almost-full, then full
      a_req = 4'b0001;
      cyc = 0;
      while (used_m < VOLUME - AMFULL_DIFF && cyc < 5000) begin step(); cyc++; end
      chk("fill_used_1020",   64'(bus.used_cnt),    64'(VOLUME - AMFULL_DIFF));
      chk("fill_almost_full", 64'(bus.almost_full), 64'(1));
      chk("fill_not_full",    64'(bus.alloc_full),  64'(0));
      cyc = 0;
      while (used_m < VOLUME && cyc < 100) begin step(); cyc++; end
      chk("fill_used_1024",   64'(bus.used_cnt),    64'(VOLUME));
      chk("fill_full",        64'(bus.alloc_full),  64'(1));
      ngnt = 0;
      for (int i = 0; i < 10; i++) begin step(); if (last_gnt) ngnt++; end
      chk("full_no_grant", 64'(ngnt), 64'(0));

      // One release while full: next grant reuses that page
      f_addr[0] = 10'd77; f_req = 4'b0001;
      step();
      run_grants(1, 20, "refill_grant");
      chk("refill_addr", 64'(last_addr), 64'(77));

      // Reset in the middle of WAIT
      f_addr[0] = 10'd100; f_addr[1] = 10'd101; f_req = 4'b0011;
      step();
      step();
      run_grants(1, 20, "pre_rst_grant");
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_wait_wr_en_1", 64'(bus.bm_wr_en_1),    64'(0));
      chk("rst_wait_used",    64'(bus.used_cnt),      64'(0));
      chk("rst_wait_err",     64'(bus.err_underflow), 64'(0));
      step();
      chk("rst_wait_idle_grant", 64'(last_gnt), 64'(1));
      a_req = '0;
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
